// File: rtl/instr_encoder.sv
// Encodes RV32I field bundles into 32-bit instruction words and streams them,
// with incrementing word addresses, to an instruction-memory write port.
module instr_encoder #(
    parameter int P_ADDR_W = 32,
    parameter int P_LEN_W  = 16
) (
    input  logic                iclk,
    input  logic                irst_n,
    input  logic                istart,
    input  logic [P_ADDR_W-1:0] ibase,
    input  logic [P_LEN_W-1:0]  ilen,
    input  logic                ivalid,
    output logic                oready_in,
    input  logic [3:0]          iclass,
    input  logic [2:0]          ifunct3,
    input  logic                ifunct7b5,
    input  logic [4:0]          ird,
    input  logic [4:0]          irs1,
    input  logic [4:0]          irs2,
    input  logic [31:0]         iimm,
    output logic                ovalid,
    input  logic                iready,
    output logic [P_ADDR_W-1:0] oaddr,
    output logic [31:0]         owdata,
    output logic                obusy,
    output logic                odone,
    output logic                oerr,
    input  logic                iclr_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t             state;
    logic [P_LEN_W-1:0] remaining;
    logic [P_LEN_W-1:0] issued;
    logic [P_LEN_W-1:0] len;

    logic [31:0] word;
    logic        legal;
    logic        range_err;
    logic        align_err;
    logic        fit12, fit13, fit21;
    logic        accept, emit, xfer, bad;
    logic [1:0]  unused_base_bits;

    assign unused_base_bits = ibase[1:0];

    // Sign-fit: all bits above the field's sign bit must equal it.
    assign fit12 = (&iimm[31:11]) | ~(|iimm[31:11]);
    assign fit13 = (&iimm[31:12]) | ~(|iimm[31:12]);
    assign fit21 = (&iimm[31:20]) | ~(|iimm[31:20]);

    always_comb begin
        word      = 32'd0;
        legal     = 1'b1;
        range_err = 1'b0;
        align_err = 1'b0;
        case (iclass)
            4'd0: begin
                word      = {iimm[11:0], irs1, ifunct3, ird, OP_LOAD};
                range_err = !fit12;
            end
            4'd1: begin
                word      = {iimm[11:5], irs2, irs1, ifunct3, iimm[4:0], OP_STORE};
                range_err = !fit12;
            end
            4'd2: word = {1'b0, ifunct7b5, 5'b00000, irs2, irs1, ifunct3, ird, OP_R};
            4'd3: begin
                word      = {iimm[12], iimm[10:5], irs2, irs1, ifunct3, iimm[4:1], iimm[11], OP_BRANCH};
                range_err = !fit13;
                align_err = iimm[0];
            end
            4'd4: begin
                if (ifunct3 == 3'b001 || ifunct3 == 3'b101)
                    word = {1'b0, ifunct7b5, 5'b00000, iimm[4:0], irs1, ifunct3, ird, OP_I};
                else
                    word = {iimm[11:0], irs1, ifunct3, ird, OP_I};
                range_err = !fit12;
            end
            4'd5: begin
                word      = {iimm[20], iimm[10:1], iimm[11], iimm[19:12], ird, OP_JAL};
                range_err = !fit21;
                align_err = iimm[0];
            end
            4'd6: word = {iimm[31:12], ird, OP_AUIPC};
            4'd7: word = {iimm[31:12], ird, OP_LUI};
            4'd8: begin
                word      = {iimm[11:0], irs1, 3'b000, ird, OP_JALR};
                range_err = !fit12;
            end
            default: legal = 1'b0;
        endcase
    end

    assign oready_in = (state == RUN) && (issued < len) && (!ovalid || iready);
    assign accept    = ivalid && oready_in;
    assign emit      = accept && legal;
    assign xfer      = ovalid && iready;
    assign bad       = accept && (!legal || range_err || align_err);
    assign obusy     = (state == RUN);

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state     <= IDLE;
            remaining <= '0;
            issued    <= '0;
            len       <= '0;
            ovalid    <= 1'b0;
            oaddr     <= '0;
            owdata    <= 32'd0;
            odone     <= 1'b0;
            oerr      <= 1'b0;
        end else begin
            odone <= 1'b0;
            // A new error wins over a simultaneous clear.
            if (bad)
                oerr <= 1'b1;
            else if (iclr_err)
                oerr <= 1'b0;

            case (state)
                IDLE: begin
                    if (istart) begin
                        oaddr     <= {ibase[P_ADDR_W-1:2], 2'b00};
                        remaining <= ilen;
                        len       <= ilen;
                        issued    <= '0;
                        ovalid    <= 1'b0;
                        if (ilen == '0) begin
                            state <= DONE;
                            odone <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (emit) begin
                        owdata <= word;
                        issued <= issued + P_LEN_W'(1);
                        ovalid <= 1'b1;
                    end else if (xfer) begin
                        ovalid <= 1'b0;
                    end
                    if (xfer) begin
                        oaddr     <= oaddr + P_ADDR_W'(4);
                        remaining <= remaining - P_LEN_W'(1);
                        if (remaining == P_LEN_W'(1)) begin
                            state <= DONE;
                            odone <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: session flow, encodings, backpressure,
// errors, address wrap, zero-length sessions and asynchronous reset.
module tb_instr_encoder;

    logic        iclk = 1'b0;
    logic        irst_n;
    logic        istart;
    logic [31:0] ibase;
    logic [15:0] ilen;
    logic        ivalid;
    logic        oready_in;
    logic [3:0]  iclass;
    logic [2:0]  ifunct3;
    logic        ifunct7b5;
    logic [4:0]  ird, irs1, irs2;
    logic [31:0] iimm;
    logic        ovalid;
    logic        iready;
    logic [31:0] oaddr;
    logic [31:0] owdata;
    logic        obusy;
    logic        odone;
    logic        oerr;
    logic        iclr_err;

    int n_cmp = 0;
    int n_bad = 0;

    instr_encoder #(.P_ADDR_W(32), .P_LEN_W(16)) dut (
        .iclk(iclk), .irst_n(irst_n), .istart(istart), .ibase(ibase), .ilen(ilen),
        .ivalid(ivalid), .oready_in(oready_in), .iclass(iclass), .ifunct3(ifunct3),
        .ifunct7b5(ifunct7b5), .ird(ird), .irs1(irs1), .irs2(irs2), .iimm(iimm),
        .ovalid(ovalid), .iready(iready), .oaddr(oaddr), .owdata(owdata),
        .obusy(obusy), .odone(odone), .oerr(oerr), .iclr_err(iclr_err)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic bundle(input logic [3:0] c, input logic [2:0] f3, input logic f7,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm);
        iclass = c; ifunct3 = f3; ifunct7b5 = f7;
        ird = rd; irs1 = rs1; irs2 = rs2; iimm = imm;
        ivalid = 1'b1;
    endtask

    task automatic start(input logic [31:0] base, input logic [15:0] n);
        ibase = base; ilen = n; istart = 1'b1;
        tick();
        istart = 1'b0;
    endtask

    initial begin
        irst_n = 1'b0; istart = 1'b0; ibase = '0; ilen = '0; ivalid = 1'b0;
        iready = 1'b1; iclr_err = 1'b0;
        bundle(4'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        ivalid = 1'b0;

        // Reset state
        tick(); tick();
        ivalid = 1'b1; #1;
        chk("rst_ovalid", {31'd0, ovalid}, 32'd0);
        chk("rst_oaddr", oaddr, 32'd0);
        chk("rst_owdata", owdata, 32'd0);
        chk("rst_odone", {31'd0, odone}, 32'd0);
        chk("rst_oerr", {31'd0, oerr}, 32'd0);
        chk("rst_busy", {31'd0, obusy}, 32'd0);
        chk("rst_ready", {31'd0, oready_in}, 32'd0);
        ivalid = 1'b0;
        irst_n = 1'b1;
        tick();

        // Basic session: addi / add / sub
        start(32'h100, 16'd3);
        chk("s1_busy", {31'd0, obusy}, 32'd1);
        chk("s1_addr0", oaddr, 32'h100);
        bundle(4'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5); #1;
        chk("s1_ready0", {31'd0, oready_in}, 32'd1);
        tick();
        chk("addi_word", owdata, 32'h00500093);
        chk("addi_addr", oaddr, 32'h100);
        chk("addi_valid", {31'd0, ovalid}, 32'd1);
        bundle(4'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0); #1;
        chk("s1_ready1", {31'd0, oready_in}, 32'd1);
        tick();
        chk("add_word", owdata, 32'h002081B3);
        chk("add_addr", oaddr, 32'h104);
        bundle(4'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        chk("sub_word", owdata, 32'h402081B3);
        chk("sub_addr", oaddr, 32'h108);
        ivalid = 1'b1; #1;
        chk("s1_ready_full", {31'd0, oready_in}, 32'd0);
        ivalid = 1'b0;
        tick();
        chk("s1_done", {31'd0, odone}, 32'd1);
        chk("s1_done_novalid", {31'd0, ovalid}, 32'd0);
        chk("s1_done_busy", {31'd0, obusy}, 32'd0);
        tick();
        chk("s1_done_once", {31'd0, odone}, 32'd0);

        // Encodings, backpressure, istart ignored during RUN
        start(32'h200, 16'd4);
        ibase = 32'h500; ilen = 16'd1; istart = 1'b1;
        iready = 1'b0;
        bundle(4'd1, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        tick();
        istart = 1'b0;
        chk("sw_word", owdata, 32'h0020A423);
        chk("sw_addr", oaddr, 32'h200);
        bundle(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8); #1;
        chk("bp_ready", {31'd0, oready_in}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_word", owdata, 32'h0020A423);
            chk("bp_addr", oaddr, 32'h200);
            chk("bp_valid", {31'd0, ovalid}, 32'd1);
            chk("bp_ready_hold", {31'd0, oready_in}, 32'd0);
        end
        iready = 1'b1; #1;
        chk("bp_release_ready", {31'd0, oready_in}, 32'd1);
        tick();
        chk("jal_word", owdata, 32'h008000EF);
        chk("jal_addr", oaddr, 32'h204);
        chk("start_ignored_busy", {31'd0, obusy}, 32'd1);
        bundle(4'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        tick();
        chk("lui_word", owdata, 32'h123452B7);
        chk("lui_addr", oaddr, 32'h208);
        bundle(4'd4, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3);
        tick();
        chk("srai_word", owdata, 32'h4030D093);
        chk("srai_addr", oaddr, 32'h20C);
        chk("stream_valid", {31'd0, ovalid}, 32'd1);
        ivalid = 1'b0;
        tick();
        chk("s2_done", {31'd0, odone}, 32'd1);
        tick();

        // Errors: misaligned branch with simultaneous clear, illegal class, clear
        start(32'h300, 16'd2);
        bundle(4'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
        iclr_err = 1'b1;
        tick();
        iclr_err = 1'b0;
        chk("beq_err", {31'd0, oerr}, 32'd1);
        chk("beq_word", owdata, 32'h00208163);
        chk("beq_valid", {31'd0, ovalid}, 32'd1);
        bundle(4'd12, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0); #1;
        chk("ill_ready", {31'd0, oready_in}, 32'd1);
        tick();
        chk("ill_novalid", {31'd0, ovalid}, 32'd0);
        chk("ill_err", {31'd0, oerr}, 32'd1);
        chk("ill_addr", oaddr, 32'h304);
        ivalid = 1'b0; iclr_err = 1'b1;
        tick();
        iclr_err = 1'b0;
        chk("clr_err", {31'd0, oerr}, 32'd0);
        chk("ill_still_busy", {31'd0, obusy}, 32'd1);
        bundle(4'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5); #1;
        chk("ill_ready_after", {31'd0, oready_in}, 32'd1);
        tick();
        chk("ill_next_word", owdata, 32'h00500093);
        chk("ill_next_addr", oaddr, 32'h304);
        ivalid = 1'b0;
        tick();
        chk("s3_done", {31'd0, odone}, 32'd1);
        tick();

        // Zero-length session
        start(32'h800, 16'd0);
        chk("len0_done", {31'd0, odone}, 32'd1);
        chk("len0_novalid", {31'd0, ovalid}, 32'd0);
        chk("len0_busy", {31'd0, obusy}, 32'd0);
        tick();
        chk("len0_done_once", {31'd0, odone}, 32'd0);

        // Address wrap, low base bits forced to zero
        start(32'hFFFF_FFFF, 16'd2);
        chk("wrap_addr0", oaddr, 32'hFFFF_FFFC);
        bundle(4'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        tick();
        chk("wrap_word0", owdata, 32'h123452B7);
        bundle(4'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        chk("wrap_addr1", oaddr, 32'h0000_0000);
        chk("wrap_word1", owdata, 32'h002081B3);
        ivalid = 1'b0;
        tick();
        chk("wrap_done", {31'd0, odone}, 32'd1);
        tick();

        // Asynchronous reset mid-session
        start(32'h400, 16'd3);
        iready = 1'b0;
        bundle(4'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        chk("pre_rst_valid", {31'd0, ovalid}, 32'd1);
        irst_n = 1'b0; #1;
        chk("arst_valid", {31'd0, ovalid}, 32'd0);
        chk("arst_addr", oaddr, 32'd0);
        chk("arst_word", owdata, 32'd0);
        chk("arst_busy", {31'd0, obusy}, 32'd0);
        tick();
        irst_n = 1'b1; iready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_novalid", {31'd0, ovalid}, 32'd0);
            chk("post_rst_ready", {31'd0, oready_in}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
